// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and result-entry helpers for the writeback stage.
// An entry is {we, waddr, wdata}: the same layout for LSU, EXU and FIFO slots.
package wb_arbiter_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;
   localparam int REG_NUM_ARCH = 32;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [REG_ADDR_BUS-1:0] ZERO_REG  = '0;
   localparam logic [REG_BUS-1:0]      ZERO_WORD = '0;

   localparam int ENTRY_W = 1 + REG_ADDR_BUS + REG_BUS;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic                    we,
                                                     input logic [REG_ADDR_BUS-1:0] waddr,
                                                     input logic [REG_BUS-1:0]      wdata);
      return {we, waddr, wdata};
   endfunction

   function automatic logic [REG_ADDR_BUS-1:0] entry_addr(input logic [ENTRY_W-1:0] e);
      return e[REG_BUS +: REG_ADDR_BUS];
   endfunction

   function automatic logic [REG_BUS-1:0] entry_data(input logic [ENTRY_W-1:0] e);
      return e[REG_BUS-1:0];
   endfunction

   // Writes to x0 or results flagged no-write are consumed silently.
   function automatic logic entry_writes(input logic [ENTRY_W-1:0] e);
      return e[ENTRY_W-1] && (entry_addr(e) != ZERO_REG);
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bundle: IDU issue/hazard port, EXU and LSU result channels, regfile write port.
// slave is the arbiter's view; master is the view of the surrounding pipeline.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic                    issue_valid_i;
   logic                    issue_we_i;
   logic [REG_ADDR_BUS-1:0] issue_waddr_i;
   logic [REG_ADDR_BUS-1:0] raddr1_i;
   logic [REG_ADDR_BUS-1:0] raddr2_i;
   logic                    stall_o;

   logic                    exu_valid_i;
   logic                    exu_ready_o;
   logic                    exu_we_i;
   logic [REG_ADDR_BUS-1:0] exu_waddr_i;
   logic [REG_BUS-1:0]      exu_wdata_i;

   logic                    lsu_valid_i;
   logic                    lsu_ready_o;
   logic [REG_ADDR_BUS-1:0] lsu_waddr_i;
   logic [REG_BUS-1:0]      lsu_wdata_i;

   logic                    we_o;
   logic [REG_ADDR_BUS-1:0] waddr_o;
   logic [REG_BUS-1:0]      wdata_o;

   modport slave (
      input  issue_valid_i, issue_we_i, issue_waddr_i, raddr1_i, raddr2_i,
      output stall_o,
      input  exu_valid_i, exu_we_i, exu_waddr_i, exu_wdata_i,
      output exu_ready_o,
      input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      output lsu_ready_o,
      output we_o, waddr_o, wdata_o
   );

   modport master (
      output issue_valid_i, issue_we_i, issue_waddr_i, raddr1_i, raddr2_i,
      input  stall_o,
      output exu_valid_i, exu_we_i, exu_waddr_i, exu_wdata_i,
      input  exu_ready_o,
      output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      input  lsu_ready_o,
      input  we_o, waddr_o, wdata_o
   );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Synchronous first-word-fall-through FIFO buffering EXU results behind LSU writes.
// Push and pop may coincide, including when full.
module wb_arbiter_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);

   // A full FIFO can still accept when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign dout = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges LSU and buffered EXU results onto the single regfile
// write port and tracks in-flight destinations so IDU can stall on RAW/WAW hazards.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int REG_NUM    = REG_NUM_ARCH
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);

   logic [ENTRY_W-1:0]      exu_entry;
   logic [ENTRY_W-1:0]      lsu_entry;
   logic [ENTRY_W-1:0]      fifo_head;
   logic [ENTRY_W-1:0]      grant_entry;
   logic                    grant_valid;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    exu_bypass;

   logic                    we_reg;
   logic [REG_ADDR_BUS-1:0] waddr_reg;
   logic [REG_BUS-1:0]      wdata_reg;

   logic [REG_NUM-1:0]      sb_reg;
   logic [REG_NUM-1:0]      sb_next;
   logic [REG_NUM-1:0]      hz_vec;
   logic                    stall;
   logic                    issue_write;

   assign exu_entry = pack_entry(bus.exu_we_i, bus.exu_waddr_i, bus.exu_wdata_i);
   assign lsu_entry = pack_entry(ENABLE, bus.lsu_waddr_i, bus.lsu_wdata_i);

   assign bus.exu_ready_o = !fifo_full;
   assign bus.lsu_ready_o = ENABLE;

   // EXU goes straight to the output register only when nothing older is queued.
   assign exu_bypass = bus.exu_valid_i && !bus.lsu_valid_i && fifo_empty;
   assign fifo_pop   = !bus.lsu_valid_i && !fifo_empty;
   assign fifo_push  = bus.exu_valid_i && !fifo_full && !exu_bypass;

   wb_arbiter_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (exu_entry),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      grant_valid = DISABLE;
      grant_entry = '0;
      if (bus.lsu_valid_i) begin
         grant_valid = ENABLE;
         grant_entry = lsu_entry;
      end else if (!fifo_empty) begin
         grant_valid = ENABLE;
         grant_entry = fifo_head;
      end else if (bus.exu_valid_i) begin
         grant_valid = ENABLE;
         grant_entry = exu_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_reg    <= DISABLE;
         waddr_reg <= ZERO_REG;
         wdata_reg <= ZERO_WORD;
      end else if (grant_valid) begin
         we_reg    <= entry_writes(grant_entry);
         waddr_reg <= entry_addr(grant_entry);
         wdata_reg <= entry_data(grant_entry);
      end else begin
         we_reg    <= DISABLE;
      end
   end

   assign bus.we_o    = we_reg;
   assign bus.waddr_o = waddr_reg;
   assign bus.wdata_o = wdata_reg;

   assign issue_write = bus.issue_valid_i && bus.issue_we_i && !stall;

   // A register being written this cycle is not a hazard: the regfile forwards it.
   // Issue set takes precedence over retire clear for the same register.
   for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
         assign hz_vec[gi]  = 1'b0;
         assign sb_next[gi] = 1'b0;
      end else begin : g_reg
         logic hit_wr;
         logic hit_set;
         assign hit_wr      = we_reg && (waddr_reg == REG_ADDR_BUS'(gi));
         assign hit_set     = issue_write && (bus.issue_waddr_i == REG_ADDR_BUS'(gi));
         assign hz_vec[gi]  = sb_reg[gi] && !hit_wr;
         assign sb_next[gi] = hit_set ? 1'b1 : (hit_wr ? 1'b0 : sb_reg[gi]);
      end
   end

   assign stall = bus.issue_valid_i &&
                  (hz_vec[bus.raddr1_i] || hz_vec[bus.raddr2_i] ||
                   (bus.issue_we_i && hz_vec[bus.issue_waddr_i]));
   assign bus.stall_o = stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_reg <= '0;
      end else begin
         sb_reg <= sb_next;
      end
   end

   wb_write_pending: assert property (@(posedge clk) disable iff (!rst_n)
      we_reg |-> sb_reg[waddr_reg]);

   wb_exu_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.exu_valid_i && !bus.exu_ready_o) |=>
         (!bus.exu_valid_i || $stable({bus.exu_we_i, bus.exu_waddr_i, bus.exu_wdata_i})));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter_if bus();

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .REG_NUM(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // reference model state
   bit [31:0]   m_sb;
   res_t        m_q[$];
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   // producers' pending results
   res_t exu_todo[$];
   res_t lsu_todo[$];
   bit   exu_hold;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hz(input logic [4:0] r);
      return (r != 5'd0) && m_sb[r] && !(m_we && (m_waddr == r));
   endfunction

   function automatic bit m_stall();
      return bus.issue_valid_i && (m_hz(bus.raddr1_i) || m_hz(bus.raddr2_i) ||
                                   (bus.issue_we_i && m_hz(bus.issue_waddr_i)));
   endfunction

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic step();
      bit   st;
      bit   acc;
      bit   granted;
      bit   in_rst;
      res_t g;
      res_t e;
      st = 1'b0;
      #1;
      in_rst = !rst_n;
      if (!in_rst) begin
         st = m_stall();
         chk("stall", 32'(bus.stall_o), 32'(st));
         chk("exu_ready", 32'(bus.exu_ready_o), 32'(m_q.size() < DEPTH));
         chk("lsu_ready", 32'(bus.lsu_ready_o), 32'd1);
      end
      if (in_rst) begin
         m_q.delete();
         m_sb    = '0;
         m_we    = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
      end else begin
         acc = bus.exu_valid_i && (m_q.size() < DEPTH);
         e = '{bus.exu_we_i, bus.exu_waddr_i, bus.exu_wdata_i};
         g = '{1'b0, 5'd0, 32'd0};
         granted = 1'b1;
         if (bus.lsu_valid_i) begin
            g = '{1'b1, bus.lsu_waddr_i, bus.lsu_wdata_i};
            if (acc) m_q.push_back(e);
         end else if (m_q.size() > 0) begin
            g = m_q.pop_front();
            if (acc) m_q.push_back(e);
         end else if (bus.exu_valid_i) begin
            g = e;
         end else begin
            granted = 1'b0;
         end
         if (m_we) m_sb[m_waddr] = 1'b0;
         if (bus.issue_valid_i && bus.issue_we_i && bus.issue_waddr_i != 5'd0 && !st)
            m_sb[bus.issue_waddr_i] = 1'b1;
         if (granted) begin
            m_we    = g.we && (g.addr != 5'd0);
            m_waddr = g.addr;
            m_wdata = g.data;
         end else begin
            m_we = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("we", 32'(bus.we_o), 32'(m_we));
      if (m_we || in_rst) begin
         chk("waddr", 32'(bus.waddr_o), 32'(m_waddr));
         chk("wdata", bus.wdata_o, m_wdata);
      end
      $display("cyc rst=%0b iv=%0b ev=%0b lv=%0b -> we=%0b waddr=%0d wdata=%08h stall=%0b",
               in_rst, bus.issue_valid_i, bus.exu_valid_i, bus.lsu_valid_i,
               bus.we_o, bus.waddr_o, bus.wdata_o, bus.stall_o);
   endtask

   // Drive producers from their pending queues, keeping an unaccepted EXU payload held.
   task automatic cycle(input bit lsu_go, input bit exu_go);
      bit acc;
      bit lsu_acc;
      bus.lsu_valid_i = lsu_go && (lsu_todo.size() > 0);
      if (bus.lsu_valid_i) begin
         bus.lsu_waddr_i = lsu_todo[0].addr;
         bus.lsu_wdata_i = lsu_todo[0].data;
      end
      bus.exu_valid_i = (exu_go || exu_hold) && (exu_todo.size() > 0);
      if (bus.exu_valid_i) begin
         bus.exu_we_i    = exu_todo[0].we;
         bus.exu_waddr_i = exu_todo[0].addr;
         bus.exu_wdata_i = exu_todo[0].data;
      end
      acc     = bus.exu_valid_i && (m_q.size() < DEPTH) && rst_n;
      lsu_acc = bus.lsu_valid_i && rst_n;
      step();
      if (lsu_acc) void'(lsu_todo.pop_front());
      if (acc) begin
         void'(exu_todo.pop_front());
         exu_hold = 1'b0;
      end else begin
         exu_hold = bus.exu_valid_i;
      end
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_we_i    = 1'b1;
      bus.issue_waddr_i = rd;
      bus.raddr1_i      = 5'd0;
      bus.raddr2_i      = 5'd0;
      cycle(1'b0, 1'b0);
      bus.issue_valid_i = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_we"}, 32'(bus.we_o), 32'd1);
      chk({tag, "_waddr"}, 32'(bus.waddr_o), 32'(a));
      chk({tag, "_wdata"}, bus.wdata_o, d);
   endtask

   initial begin
      bit         iss_ok;
      logic       iwe;
      logic [4:0] iwa;

      bus.issue_valid_i = 0; bus.issue_we_i = 0; bus.issue_waddr_i = 0;
      bus.raddr1_i = 0; bus.raddr2_i = 0;
      bus.exu_valid_i = 0; bus.exu_we_i = 0; bus.exu_waddr_i = 0; bus.exu_wdata_i = 0;
      bus.lsu_valid_i = 0; bus.lsu_waddr_i = 0; bus.lsu_wdata_i = 0;
      exu_hold = 1'b0;
      m_sb = '0; m_we = 0; m_waddr = 0; m_wdata = 0;

      // reset
      rst_n = 1'b0;
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      rst_n = 1'b1;
      chk("rst_stall", 32'(bus.stall_o), 32'd0);
      chk("rst_exu_ready", 32'(bus.exu_ready_o), 32'd1);

      // EXU-only write with RAW stall then forward
      issue_rd(5'd5);
      exu_todo.push_back('{1'b1, 5'd5, 32'h1234});
      bus.issue_valid_i = 1'b1; bus.issue_we_i = 1'b0; bus.raddr1_i = 5'd5;
      #1 chk("t1_raw", 32'(bus.stall_o), 32'd1);
      cycle(1'b0, 1'b1);
      chk_wr("t1", 5'd5, 32'h1234);
      chk("t1_fwd", 32'(bus.stall_o), 32'd0);
      cycle(1'b0, 1'b0);
      bus.issue_valid_i = 1'b0;

      // LSU/EXU contention
      issue_rd(5'd7);
      issue_rd(5'd8);
      lsu_todo.push_back('{1'b1, 5'd7, 32'hAA});
      exu_todo.push_back('{1'b1, 5'd8, 32'hBB});
      cycle(1'b1, 1'b1);
      chk_wr("t2_lsu", 5'd7, 32'hAA);
      chk("t2_rdy", 32'(bus.exu_ready_o), 32'd1);
      cycle(1'b0, 1'b0);
      chk_wr("t2_fifo", 5'd8, 32'hBB);

      // backpressure and in-order drain
      for (int r = 1; r <= 3; r++) begin
         issue_rd(5'(r));
         lsu_todo.push_back('{1'b1, 5'(r), 32'(100 + r)});
      end
      for (int r = 10; r <= 12; r++) begin
         issue_rd(5'(r));
         exu_todo.push_back('{1'b1, 5'(r), 32'(200 + r)});
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1);
         if (i == 1) chk("t3_full", 32'(bus.exu_ready_o), 32'd0);
      end
      for (int r = 10; r <= 12; r++) begin
         cycle(1'b0, 1'b1);
         chk_wr("t3_drain", 5'(r), 32'(200 + r));
      end

      // RAW stall held until the write cycle
      issue_rd(5'd3);
      exu_todo.push_back('{1'b1, 5'd3, 32'h33});
      bus.issue_valid_i = 1'b1; bus.issue_we_i = 1'b0; bus.raddr1_i = 5'd3;
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0);
         chk("t4_stall", 32'(bus.stall_o), 32'd1);
      end
      cycle(1'b0, 1'b1);
      chk("t4_fwd", 32'(bus.stall_o), 32'd0);
      bus.issue_valid_i = 1'b0; bus.raddr1_i = 5'd0;
      cycle(1'b0, 1'b0);

      // x0 and no-write results
      bus.issue_valid_i = 1'b1; bus.issue_we_i = 1'b1; bus.issue_waddr_i = 5'd0;
      bus.raddr1_i = 5'd0; bus.raddr2_i = 5'd6;
      exu_todo.push_back('{1'b1, 5'd0, 32'h55});
      exu_todo.push_back('{1'b0, 5'd6, 32'h66});
      cycle(1'b0, 1'b1);
      chk("t5_x0", 32'(bus.we_o), 32'd0);
      cycle(1'b0, 1'b1);
      chk("t5_nowr", 32'(bus.we_o), 32'd0);
      chk("t5_nostall", 32'(bus.stall_o), 32'd0);
      bus.issue_valid_i = 1'b0; bus.raddr2_i = 5'd0;

      // reset with FIFO entries and scoreboard bits in flight
      issue_rd(5'd13); issue_rd(5'd14); issue_rd(5'd15); issue_rd(5'd16);
      lsu_todo.push_back('{1'b1, 5'd15, 32'h15});
      lsu_todo.push_back('{1'b1, 5'd16, 32'h16});
      exu_todo.push_back('{1'b1, 5'd13, 32'h13});
      exu_todo.push_back('{1'b1, 5'd14, 32'h14});
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      chk("t6_full", 32'(bus.exu_ready_o), 32'd0);
      rst_n = 1'b0;
      cycle(1'b0, 1'b0);
      rst_n = 1'b1;
      exu_todo.delete(); lsu_todo.delete(); exu_hold = 1'b0;
      chk("t6_we", 32'(bus.we_o), 32'd0);
      chk("t6_rdy", 32'(bus.exu_ready_o), 32'd1);
      bus.issue_valid_i = 1'b1; bus.issue_we_i = 1'b1; bus.issue_waddr_i = 5'd13;
      bus.raddr1_i = 5'd14; bus.raddr2_i = 5'd13;
      #1 chk("t6_stall", 32'(bus.stall_o), 32'd0);
      bus.issue_valid_i = 1'b0;
      cycle(1'b0, 1'b0);
      chk("t6_empty", 32'(bus.we_o), 32'd0);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         iwe = ($urandom_range(0, 3) != 0);
         iwa = 5'($urandom_range(0, 7));
         bus.issue_valid_i = 1'($urandom_range(0, 1));
         bus.issue_we_i    = iwe;
         bus.issue_waddr_i = iwa;
         bus.raddr1_i      = 5'($urandom_range(0, 7));
         bus.raddr2_i      = 5'($urandom_range(0, 7));
         iss_ok = bus.issue_valid_i && !m_stall();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
         if (iss_ok) begin
            if (iwe && iwa != 5'd0) begin
               if ($urandom_range(0, 1) != 0) lsu_todo.push_back('{1'b1, iwa, $urandom});
               else                           exu_todo.push_back('{1'b1, iwa, $urandom});
            end else if ($urandom_range(0, 1) != 0) begin
               exu_todo.push_back('{iwe, iwa, $urandom});
            end
         end
      end

      // drain and sweep every register for leftover hazards
      bus.issue_valid_i = 1'b0;
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1);
      bus.issue_we_i = 1'b0; bus.raddr2_i = 5'd0;
      for (int r = 1; r < 32; r++) begin
         bus.issue_valid_i = 1'b1;
         bus.raddr1_i = 5'(r);
         cycle(1'b0, 1'b0);
      end
      bus.issue_valid_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
